// File: rtl/acl_mode_sequencer.sv
// Mode sequencer for the PMOD ACL2 driver: one-hot switch mode select, init/start
// handshake over the driver ready line, handshake timeout, fault state and re-arm.
module acl_mode_sequencer #(
  parameter int unsigned N_MODES        = 2,
  parameter int unsigned SW_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FAULT_CNT_W    = 8
) (
  input  logic                   i_clk_20mhz,
  input  logic                   i_rst_20mhz,
  input  logic                   i_acl_command_ready,
  input  logic [SW_WIDTH-1:0]    i_switches_debounced,
  output logic                   o_reading_inactive,
  output logic                   o_active_init_display,
  output logic                   o_active_run_display,
  output logic [N_MODES-1:0]     o_mode_onehot,
  output logic [N_MODES-1:0]     o_acl_cmd_init,
  output logic [N_MODES-1:0]     o_acl_cmd_start,
  output logic                   o_acl_cmd_soft_reset,
  output logic                   o_fault,
  output logic [FAULT_CNT_W-1:0] o_fault_count
);

  localparam int unsigned IDX_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int unsigned CNT_W = $clog2(SW_WIDTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT_REQ   = 3'd1,
    S_INIT_WAIT  = 3'd2,
    S_START_REQ  = 3'd3,
    S_START_DONE = 3'd4,
    S_RUN        = 3'd5,
    S_RESET_REQ  = 3'd6,
    S_FAULT      = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SW_WIDTH-1:0]    sw_q, sw_d;
  logic [N_MODES-1:0]     mode_q, mode_d;
  logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic [CNT_W-1:0]       sel_cnt;
  logic                   sel_hi;
  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic [N_MODES-1:0]     sel_onehot;
  logic [N_MODES-1:0]     idx_onehot;
  logic                   timed;
  logic                   tmo_hit;

  // Valid selection: exactly one low mode bit set, nothing above the mode range.
  always_comb begin
    sel_cnt = '0;
    sel_hi  = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < SW_WIDTH; i++) begin
      if (i_switches_debounced[i]) begin
        if (i < N_MODES) begin
          sel_cnt = sel_cnt + CNT_W'(1);
          sel_idx = IDX_W'(i);
        end else begin
          sel_hi = 1'b1;
        end
      end
    end
    sel_valid = (sel_cnt == CNT_W'(1)) && !sel_hi;
  end

  always_comb begin
    sel_onehot = '0;
    idx_onehot = '0;
    for (int unsigned k = 0; k < N_MODES; k++) begin
      sel_onehot[k] = (sel_idx == IDX_W'(k));
      idx_onehot[k] = (idx_q == IDX_W'(k));
    end
  end

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next state and Moore output decode.
  always_comb begin
    state_d               = state_q;
    idx_d                 = idx_q;
    sw_d                  = sw_q;
    mode_d                = mode_q;
    fault_cnt_d           = fault_cnt_q;
    timed                 = 1'b0;
    o_reading_inactive    = 1'b0;
    o_active_init_display = 1'b0;
    o_active_run_display  = 1'b0;
    o_acl_cmd_init        = '0;
    o_acl_cmd_start       = '0;
    o_acl_cmd_soft_reset  = 1'b0;
    o_fault               = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_reading_inactive = 1'b1;
        if (i_acl_command_ready && sel_valid) begin
          state_d = S_INIT_REQ;
          idx_d   = sel_idx;
          sw_d    = i_switches_debounced;
          mode_d  = sel_onehot;
        end
      end
      S_INIT_REQ: begin
        o_active_init_display = 1'b1;
        o_acl_cmd_init        = idx_onehot;
        timed                 = 1'b1;
        if (!i_acl_command_ready) state_d = S_INIT_WAIT;
        else if (tmo_hit)         state_d = S_FAULT;
      end
      S_INIT_WAIT: begin
        o_active_init_display = 1'b1;
        timed                 = 1'b1;
        if (i_acl_command_ready) state_d = S_START_REQ;
        else if (tmo_hit)        state_d = S_FAULT;
      end
      S_START_REQ: begin
        o_active_init_display = 1'b1;
        o_acl_cmd_start       = idx_onehot;
        timed                 = 1'b1;
        if (!i_acl_command_ready) state_d = S_START_DONE;
        else if (tmo_hit)         state_d = S_FAULT;
      end
      S_START_DONE: begin
        o_active_init_display = 1'b1;
        state_d               = S_RUN;
      end
      S_RUN: begin
        o_active_run_display = 1'b1;
        if (i_switches_debounced != sw_q) state_d = S_RESET_REQ;
      end
      S_RESET_REQ: begin
        o_acl_cmd_soft_reset = 1'b1;
        timed                = 1'b1;
        if (i_acl_command_ready) state_d = S_IDLE;
        else if (tmo_hit)        state_d = S_FAULT;
      end
      S_FAULT: begin
        o_fault = 1'b1;
        if (i_switches_debounced == '0) state_d = S_RESET_REQ;
      end
      default: begin
        o_reading_inactive = 1'b1;
        state_d            = S_IDLE;
      end
    endcase

    // Entry actions: mode indicator drops on RESET_REQ/FAULT, fault count saturates.
    if (state_d != state_q) begin
      if (state_d == S_RESET_REQ || state_d == S_FAULT) mode_d = '0;
      if (state_d == S_FAULT && fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
    end

    tmo_d = (state_d != state_q || !timed) ? '0 : tmo_q + TMO_W'(1);
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sw_q        <= '0;
      mode_q      <= '0;
      fault_cnt_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sw_q        <= sw_d;
      mode_q      <= mode_d;
      fault_cnt_q <= fault_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_mode_onehot = mode_q;
  assign o_fault_count = fault_cnt_q;

endmodule

// File: tb/tb_acl_mode_sequencer.sv
// Directed bench for acl_mode_sequencer: a 2-mode instance with a 2-bit fault
// counter and a 4-mode instance, both with a 16-cycle handshake timeout.
module tb_acl_mode_sequencer;

  logic clk;
  logic rst;

  logic       rdy_a;
  logic [3:0] sw_a;
  logic       ri_a, id_a, rd_a, srst_a, fault_a;
  logic [1:0] mode_a, init_a, start_a, fcnt_a;

  logic       rdy_b;
  logic [3:0] sw_b;
  logic       ri_b, id_b, rd_b, srst_b, fault_b;
  logic [3:0] mode_b, init_b, start_b;
  logic [7:0] fcnt_b;

  int errors = 0;
  int checks = 0;

  acl_mode_sequencer #(
    .N_MODES(2), .SW_WIDTH(4), .TIMEOUT_CYCLES(16), .FAULT_CNT_W(2)
  ) dut_a (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst),
    .i_acl_command_ready(rdy_a), .i_switches_debounced(sw_a),
    .o_reading_inactive(ri_a), .o_active_init_display(id_a),
    .o_active_run_display(rd_a), .o_mode_onehot(mode_a),
    .o_acl_cmd_init(init_a), .o_acl_cmd_start(start_a),
    .o_acl_cmd_soft_reset(srst_a), .o_fault(fault_a), .o_fault_count(fcnt_a)
  );

  acl_mode_sequencer #(
    .N_MODES(4), .SW_WIDTH(4), .TIMEOUT_CYCLES(16), .FAULT_CNT_W(8)
  ) dut_b (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst),
    .i_acl_command_ready(rdy_b), .i_switches_debounced(sw_b),
    .o_reading_inactive(ri_b), .o_active_init_display(id_b),
    .o_active_run_display(rd_b), .o_mode_onehot(mode_b),
    .o_acl_cmd_init(init_b), .o_acl_cmd_start(start_b),
    .o_acl_cmd_soft_reset(srst_b), .o_fault(fault_b), .o_fault_count(fcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy_a = 1'b0; sw_a = 4'b0000; rdy_b = 1'b0; sw_b = 4'b0000;
    tick(2);
    check("rst_inactive", 32'(ri_a), 32'd1);
    check("rst_mode", 32'(mode_a), 32'd0);
    check("rst_cmds", 32'({init_a, start_a, srst_a, fault_a}), 32'd0);
    check("rst_fcnt", 32'(fcnt_a), 32'd0);
    rst = 1'b0;

    // Mode 0 handshake
    rdy_a = 1'b1; sw_a = 4'b0001;
    tick(1);
    check("m0_init", 32'(init_a), 32'b01);
    check("m0_init_disp", 32'(id_a), 32'd1);
    check("m0_mode", 32'(mode_a), 32'b01);
    rdy_a = 1'b0;
    tick(1);
    check("m0_wait_init", 32'(init_a), 32'd0);
    tick(2);
    check("m0_wait_disp", 32'(id_a), 32'd1);
    rdy_a = 1'b1;
    tick(1);
    check("m0_start", 32'(start_a), 32'b01);
    rdy_a = 1'b0;
    tick(1);
    check("m0_done_start", 32'(start_a), 32'd0);
    check("m0_done_disp", 32'(id_a), 32'd1);
    tick(1);
    check("m0_run", 32'(rd_a), 32'd1);
    check("m0_run_mode", 32'(mode_a), 32'b01);

    // Re-arm on switch change while running
    sw_a = 4'b0010;
    tick(1);
    check("rearm_srst", 32'(srst_a), 32'd1);
    check("rearm_mode", 32'(mode_a), 32'd0);
    rdy_a = 1'b1;
    tick(1);
    check("rearm_idle", 32'(ri_a), 32'd1);
    tick(1);
    check("m1_init", 32'(init_a), 32'b10);
    check("m1_mode", 32'(mode_a), 32'b10);
    rdy_a = 1'b0; tick(1);
    rdy_a = 1'b1; tick(1);
    check("m1_start", 32'(start_a), 32'b10);
    rdy_a = 1'b0; tick(2);
    check("m1_run", 32'(rd_a), 32'd1);

    // Back to IDLE via all-zero switches, then illegal patterns stay idle
    sw_a = 4'b0000; tick(1);
    check("zero_srst", 32'(srst_a), 32'd1);
    rdy_a = 1'b1; tick(1);
    check("zero_idle", 32'(ri_a), 32'd1);
    sw_a = 4'b1000; tick(2);
    check("hi_bit_idle", 32'(ri_a), 32'd1);
    sw_a = 4'b0011; tick(2);
    check("two_bit_idle", 32'(ri_a), 32'd1);

    // INIT_REQ timeout: 16 cycles then FAULT
    sw_a = 4'b0001; tick(1);
    tick(15);
    check("tmo_still_init", 32'(init_a), 32'b01);
    check("tmo_no_fault", 32'(fault_a), 32'd0);
    tick(1);
    check("tmo_fault", 32'(fault_a), 32'd1);
    check("tmo_fcnt1", 32'(fcnt_a), 32'd1);
    check("tmo_cmds", 32'({init_a, start_a, srst_a}), 32'd0);
    check("tmo_mode", 32'(mode_a), 32'd0);
    tick(2);
    check("fault_hold", 32'(fault_a), 32'd1);
    sw_a = 4'b0000; tick(1);
    check("fault_srst", 32'(srst_a), 32'd1);
    tick(1);
    check("fault_idle", 32'(ri_a), 32'd1);

    // Saturation: second INIT_REQ timeout, then repeated RESET_REQ timeouts
    sw_a = 4'b0001; tick(1); tick(16);
    check("sat_fcnt2", 32'(fcnt_a), 32'd2);
    sw_a = 4'b0000; rdy_a = 1'b0;
    for (int e = 3; e <= 5; e++) begin
      tick(1);
      check("sat_srst", 32'(srst_a), 32'd1);
      tick(15);
      check("sat_srst_hold", 32'(fault_a), 32'd0);
      tick(1);
      check("sat_fault", 32'(fault_a), 32'd1);
      check("sat_fcnt", 32'(fcnt_a), (e > 3) ? 32'd3 : 32'(e));
    end
    rdy_a = 1'b1; tick(2);
    check("sat_idle", 32'(ri_a), 32'd1);

    // Ready rise on the 16th INIT_WAIT cycle wins over timeout
    sw_a = 4'b0001; tick(1);
    rdy_a = 1'b0; tick(1);
    tick(15);
    check("edge_wait_disp", 32'(id_a), 32'd1);
    check("edge_wait_fault", 32'(fault_a), 32'd0);
    rdy_a = 1'b1; tick(1);
    check("edge_start", 32'(start_a), 32'b01);
    check("edge_no_fault", 32'(fault_a), 32'd0);

    // Synchronous reset in START_REQ
    rst = 1'b1; tick(1);
    check("mid_rst_inactive", 32'(ri_a), 32'd1);
    check("mid_rst_cmds", 32'({init_a, start_a, srst_a, fault_a}), 32'd0);
    check("mid_rst_mode", 32'(mode_a), 32'd0);
    check("mid_rst_fcnt", 32'(fcnt_a), 32'd0);
    rst = 1'b0;

    // Four-mode instance
    rdy_b = 1'b1; sw_b = 4'b0110; tick(2);
    check("b_two_bit_idle", 32'(ri_b), 32'd1);
    sw_b = 4'b0100; tick(1);
    check("b_init", 32'(init_b), 32'b0100);
    check("b_mode", 32'(mode_b), 32'b0100);
    rdy_b = 1'b0; tick(1);
    rdy_b = 1'b1; tick(1);
    check("b_start", 32'(start_b), 32'b0100);
    rdy_b = 1'b0; tick(2);
    check("b_run", 32'(rd_b), 32'd1);
    check("b_run_mode", 32'(mode_b), 32'b0100);
    check("b_fcnt", 32'(fcnt_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
